// File: rtl/uart_pkg.sv
// uart_pkg: state encodings for the uart_core transmitter and receiver FSMs and
// the parity-sense constants shared by uart_core and its bench.
package uart_pkg;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through RX FIFO. A push into a full FIFO only lands
// when a pop frees the head slot in the same cycle; pops on empty are ignored.
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero while empty so the data and error outputs are clean after reset.
  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1-style UART transmitter and receiver with an RX FIFO.
// Define UART_PARITY_EN to add one parity bit per frame (sense set by PARITY_ODD).
module uart_core #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int RX_DEPTH     = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_tx,
  input  logic              i_rx,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_rx_frame_err,
  output logic              o_rx_parity_err,
  output logic              o_rx_overrun,
  input  logic              i_err_clr,
  output logic [2:0]        dbg_tx_state,
  output logic [2:0]        dbg_rx_state
);
  import uart_pkg::*;

  // Handshakes: a word moves when valid && ready are both high at a rising clk edge.
  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
`ifdef UART_PARITY_EN
  localparam int  FW = DATA_W + 2;
  localparam logic odd_sense = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;
`else
  localparam int  FW = DATA_W + 1;
`endif

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 4 || STOP_BITS < 1 || STOP_BITS > 2 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_cfg
    $error("uart_core: illegal parameter set");
  end

  tx_state_e         tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     tx_idx;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_line;
`ifdef UART_PARITY_EN
  logic              tx_par;
`endif

  assign o_tx_ready   = (tx_state == TX_IDLE);
  assign o_tx         = tx_line;
  assign dbg_tx_state = tx_state;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: if (i_tx_valid) begin
          tx_state <= TX_START;
          tx_line  <= 1'b0;
          tx_shift <= i_tx_data;
          tx_cnt   <= '0;
`ifdef UART_PARITY_EN
          tx_par   <= (^i_tx_data) ^ odd_sense;
`endif
        end
        TX_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_idx   <= '0;
          tx_line  <= tx_shift[0];
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state <= TX_PARITY;
            tx_line  <= tx_par;
`else
            tx_state <= TX_STOP;
            tx_line  <= 1'b1;
`endif
          end else begin
            tx_idx   <= tx_idx + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx_line  <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_PARITY: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_state <= TX_STOP;
          tx_line  <= 1'b1;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_STOP: if (tx_cnt == STOP_LAST) begin
          tx_cnt   <= '0;
          tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  logic              rx_s1, rx_s2, rx_prev;
  rx_state_e         rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_idx;
  logic [DATA_W-1:0] rx_shift;
  logic              push;
  logic [FW-1:0]     push_word;
  logic [FW-1:0]     head;
  logic              fifo_full, fifo_empty;
`ifdef UART_PARITY_EN
  logic              rx_perr;
  assign push_word = {rx_shift, ~rx_s2, rx_perr};
`else
  assign push_word = {rx_shift, ~rx_s2};
`endif

  // Only the first stop bit is sampled; returning to idle at its mid-point keeps
  // the receiver ready for a start edge that follows a short stop period.
  assign push         = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
  assign dbg_rx_state = rx_state;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_perr  <= 1'b0;
`endif
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_idx   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
          if (rx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state <= RX_PARITY;
`else
            rx_state <= RX_STOP;
`endif
          end else rx_idx <= rx_idx + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_PARITY: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= RX_STOP;
`ifdef UART_PARITY_EN
          rx_perr  <= rx_s2 ^ (^rx_shift) ^ odd_sense;
`endif
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_fifo #(.WIDTH(FW), .DEPTH(RX_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (i_reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (i_rx_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_rx_valid = !fifo_empty;
`ifdef UART_PARITY_EN
  assign o_rx_data       = head[FW-1:2];
  assign o_rx_frame_err  = head[1];
  assign o_rx_parity_err = head[0];
`else
  assign o_rx_data       = head[FW-1:1];
  assign o_rx_frame_err  = head[0];
  assign o_rx_parity_err = 1'b0;
`endif

  // A dropped frame takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) o_rx_overrun <= 1'b0;
    else if (push && fifo_full && !(o_rx_valid && i_rx_ready)) o_rx_overrun <= 1'b1;
    else if (i_err_clr) o_rx_overrun <= 1'b0;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, clocks per bit (legal >= 4).
REQ-003 The block SHALL have parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-004 The block SHALL have parameter RX_DEPTH, default 16, RX FIFO entries (power of two, >= 2).
REQ-005 The block SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd).
REQ-006 The block SHALL have the following ports, each with the stated direction, width and meaning:
- clk  in  1  sole clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_tx_data  in  DATA_W  transmit word.
- i_tx_valid  in  1  transmit request.
- o_tx_ready  out  1  transmitter can accept a word.
- o_tx  out  1  serial output; idles high.
- i_rx  in  1  serial input; asynchronous to clk.
- o_rx_data  out  DATA_W  head-of-FIFO word.
- o_rx_valid  out  1  FIFO not empty.
- i_rx_ready  in  1  consumer pops head.
- o_rx_frame_err  out  1  head word had a low stop bit.
- o_rx_parity_err  out  1  head word failed parity.
- o_rx_overrun  out  1  sticky; a frame was dropped because the FIFO was full.
- i_err_clr  in  1  clears o_rx_overrun.

Function
REQ-007 TX SHALL use states IDLE, START, DATA, PARITY, STOP; o_tx_ready SHALL be 1 only in IDLE.
REQ-008 A word SHALL be accepted when i_tx_valid && o_tx_ready; the start bit SHALL begin on o_tx the following cycle.
REQ-009 Each TX bit SHALL last exactly CLKS_PER_BIT cycles; data SHALL go out LSB first; STOP SHALL last STOP_BITS bit periods.
REQ-010 TX SHALL return to IDLE, with o_tx_ready=1, on the cycle after the last stop-bit period ends; back-to-back accepts SHALL produce no idle gap.
REQ-011 i_rx SHALL pass through a 2-flop synchroniser before any use.
REQ-012 RX SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-013 RX SHALL leave IDLE on a synchronised falling edge.
REQ-014 RX SHALL re-sample at CLKS_PER_BIT/2 and SHALL return to IDLE if the line is high (false start).
REQ-015 RX SHALL sample data, parity and the first stop bit at bit mid-points.
REQ-016 At the first stop-bit mid-point, RX SHALL push {data, frame_err, parity_err} and SHALL return to IDLE immediately, so the next start edge is detectable.
REQ-017 A push into a full FIFO SHALL be dropped and SHALL set o_rx_overrun, unless a pop occurs in the same cycle; a simultaneous push and pop on a full FIFO SHALL both succeed.
REQ-018 The FIFO SHALL be first-word-fall-through: o_rx_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-019 A pop SHALL occur on o_rx_valid && i_rx_ready; a pop on an empty FIFO SHALL be ignored.
REQ-020 Read and write pointers SHALL be $clog2(RX_DEPTH)+1 bits and SHALL wrap naturally.
REQ-021 o_rx_overrun SHALL clear on i_err_clr; a set in the same cycle as i_err_clr SHALL win.

Reset
REQ-022 On i_reset_n low, all logic SHALL reset asynchronously:
- o_tx=1, o_tx_ready=1.
- Both FSMs in IDLE.
- FIFO empty (o_rx_valid=0).
- o_rx_data=0, all error outputs 0.
- Synchroniser flops=1.
REQ-023 A reset mid-frame SHALL abort the frame; no partial word SHALL be pushed.

Configuration
REQ-024 With macro UART_PARITY_EN defined, TX SHALL append one parity bit after the data bits, and RX SHALL check it and flag mismatches on o_rx_parity_err.
REQ-025 Without UART_PARITY_EN, the PARITY state SHALL be skipped in TX and RX, and o_rx_parity_err SHALL be tied to 0.

Structure
REQ-026 Package uart_pkg SHALL hold the tx/rx state enums and the PARITY_EVEN/PARITY_ODD constants.
REQ-027 The RX FIFO SHALL be the sub-module uart_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-028 With CLKS_PER_BIT=4, send TX 0xA5 -> o_tx shows 0, 1,0,1,0,0,1,0,1, 1; each bit 4 cycles; o_tx_ready low for 40 cycles.
REQ-029 Loop o_tx to i_rx and send 0x3C, then 0xC3 back-to-back -> FIFO outputs 0x3C then 0xC3 with no errors.
REQ-030 Drive a 1-cycle low glitch on i_rx -> no push; RX back in IDLE.
REQ-031 Hold i_rx_ready=0 and send RX_DEPTH+1 frames -> FIFO holds the first 16, o_rx_overrun=1; i_err_clr clears it.
REQ-032 Send a frame with a low stop bit -> o_rx_frame_err=1 with the word. With UART_PARITY_EN, send a frame with a corrupted parity bit -> o_rx_parity_err=1.
REQ-033 Assert i_reset_n low mid-TX-data -> o_tx=1 immediately; no RX word pushed afterwards.
